iter_factorial_core: RTL

Responder side of the factorial request/result channel pair. It accepts an operand `n` over a ready/valid input channel and computes `n!` iteratively, one multiply per cycle, truncated to `WIDTH` bits. It returns the product over a ready/valid output channel that honours backpressure. It is the compute core that a launch wrapper drives: the wrapper presents `n` once and consumes the result.

---
 rtl/iter_factorial_core.sv | 94 +++++++++
 1 files changed

// File: rtl/iter_factorial_core.sv
// Iterative factorial responder: accepts n over a ready/valid channel and
// returns n! truncated to WIDTH bits, one multiply per cycle. The result is
// held under backpressure until it is consumed.
module iter_factorial_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] n_data,
  input  logic             n_vld,
  output logic             n_rdy,
  output logic [WIDTH-1:0] result_data,
  output logic             result_vld,
  input  logic             result_rdy,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod;
  logic               in_xfer;
  logic               out_xfer;
  logic               last_step;

  // Full-width product; only the low half is kept (wraps mod 2^WIDTH).
  assign prod      = {{WIDTH{1'b0}}, acc_q} * {{WIDTH{1'b0}}, cnt_q};
  assign in_xfer   = n_vld && (state_q == IDLE);
  assign out_xfer  = result_rdy && (state_q == DONE);
  // cnt of 0 or 1 contributes nothing further to the product.
  assign last_step = (cnt_q <= ONE);

  // State, accumulator and counter registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic for the request lifecycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_xfer)   state_d = BUSY;
      BUSY:    if (last_step) state_d = DONE;
      DONE:    if (out_xfer)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load on accept, multiply-and-decrement while busy, else hold.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_xfer) begin
          acc_d = ONE;
          cnt_d = n_data;
        end
      end
      BUSY: begin
        if (!last_step) begin
          acc_d = prod[WIDTH-1:0];
          cnt_d = cnt_q - ONE;
        end
      end
      default: ;
    endcase
  end

  // Output decode; rst gates n_rdy so nothing is accepted during reset.
  always_comb begin
    n_rdy       = (state_q == IDLE) && !rst;
    result_vld  = (state_q == DONE);
    result_data = acc_q;
    busy        = (state_q != IDLE);
  end

endmodule
